// File: rtl/pifo_root_ctrl.sv
// rtl/pifo_root_ctrl.sv - root PIFO atom-array sequencer: insert/pop/CPU arbitration, flush, occupancy
// Optional CPU write path is built only when PIFO_CTRL_CPU_WRITE_EN is defined.
module pifo_root_ctrl #(
  parameter int ELEMENT_WIDTH       = 32,
  parameter int ELEMENT_RANK_WIDTH  = 19,
  parameter int RANK_START_POS      = 12,
  parameter int RANK_END_POS        = 30,
  parameter int PIFO_INFO_VALID_POS = 31,
  parameter int PIFO_DEPTH          = 16,
  parameter int COUNT_WIDTH         = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_insert_valid,
  input  logic [ELEMENT_WIDTH-1:0] in_insert_data,
  output logic                     out_insert_ready,
  input  logic                     in_pop_req,
  output logic                     out_pop_valid,
  output logic [ELEMENT_WIDTH-1:0] out_pop_data,
  input  logic                     in_cpu_wr_en,
  input  logic [ELEMENT_WIDTH-1:0] in_cpu_wr_data,
  output logic                     out_cpu_wr_busy,
  input  logic                     in_flush,
  output logic                     out_ctl_insert,
  output logic                     out_ctl_pop,
  output logic [ELEMENT_WIDTH-1:0] out_pifo_input,
  input  logic [ELEMENT_WIDTH-1:0] in_head_element,
  output logic [COUNT_WIDTH-1:0]   out_count,
  output logic                     out_full,
  output logic                     out_empty
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic                     pop_valid_q, pop_valid_d;
  logic [ELEMENT_WIDTH-1:0] pop_data_q, pop_data_d;
  logic                     cpu_busy_q;
  logic [ELEMENT_WIDTH-1:0] cpu_data_q;

  logic                     idle, full, empty, grant, space, dp_hs, cpu_go, ins_valid;
  logic [ELEMENT_WIDTH-1:0] ins_elem;
  logic [ELEMENT_RANK_WIDTH-1:0] new_rank, head_rank;

  assign idle   = (state_q == IDLE);
  assign full   = (count_q == COUNT_WIDTH'(PIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign grant  = idle & in_pop_req & ~empty;
  // A pop in the same cycle frees the slot the insert needs, so full is no barrier then.
  assign space  = ~full | grant;
  assign dp_hs  = in_insert_valid & idle & space;
  assign cpu_go = cpu_busy_q & idle & ~dp_hs & space;

  assign ins_elem  = dp_hs ? in_insert_data : (cpu_go ? cpu_data_q : in_insert_data);
  assign ins_valid = (dp_hs | cpu_go) & ins_elem[PIFO_INFO_VALID_POS];
  assign new_rank  = ins_elem[RANK_END_POS:RANK_START_POS];
  assign head_rank = in_head_element[RANK_END_POS:RANK_START_POS];

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    pop_valid_d    = 1'b0;
    pop_data_d     = pop_data_q;
    out_ctl_insert = 1'b0;
    out_ctl_pop    = 1'b0;
    if (state_q == FLUSH) begin
      out_ctl_pop = ~empty;
      if (!empty) count_d = count_q - COUNT_WIDTH'(1);
      if (count_q <= COUNT_WIDTH'(1)) state_d = IDLE;
    end else begin
      if (ins_valid && in_pop_req) begin
        pop_valid_d = 1'b1;
        if (!empty && new_rank >= head_rank) begin
          out_ctl_insert = 1'b1;
          out_ctl_pop    = 1'b1;
          pop_data_d     = in_head_element;
        end else begin
          // New element would be the head anyway: hand it straight back.
          pop_data_d = ins_elem;
        end
      end else if (ins_valid) begin
        out_ctl_insert = 1'b1;
        count_d        = count_q + COUNT_WIDTH'(1);
      end else if (grant) begin
        out_ctl_pop = 1'b1;
        count_d     = count_q - COUNT_WIDTH'(1);
        pop_valid_d = 1'b1;
        pop_data_d  = in_head_element;
      end
      if (in_flush) state_d = FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

`ifdef PIFO_CTRL_CPU_WRITE_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_busy_q <= 1'b0;
      cpu_data_q <= '0;
    end else if (in_cpu_wr_en && !cpu_busy_q) begin
      cpu_busy_q <= 1'b1;
      cpu_data_q <= in_cpu_wr_data;
    end else if (cpu_go) begin
      cpu_busy_q <= 1'b0;
    end
  end
`else
  logic unused_cpu;
  assign unused_cpu = ^{in_cpu_wr_en, in_cpu_wr_data};
  assign cpu_busy_q = 1'b0;
  assign cpu_data_q = '0;
`endif

  assign out_insert_ready = idle & space;
  assign out_pop_valid    = pop_valid_q;
  assign out_pop_data     = pop_data_q;
  assign out_cpu_wr_busy  = cpu_busy_q;
  assign out_pifo_input   = ins_elem;
  assign out_count        = count_q;
  assign out_full         = full;
  assign out_empty        = empty;

endmodule

// File: tb/tb_pifo_root_ctrl.sv
// tb/tb_pifo_root_ctrl.sv - randomized bench for pifo_root_ctrl against a sorted-queue PIFO model
module tb_pifo_root_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_insert_valid = 1'b0;
  logic [31:0] in_insert_data = '0;
  logic        out_insert_ready;
  logic        in_pop_req = 1'b0;
  logic        out_pop_valid;
  logic [31:0] out_pop_data;
  logic        in_cpu_wr_en = 1'b0;
  logic [31:0] in_cpu_wr_data = '0;
  logic        out_cpu_wr_busy;
  logic        in_flush = 1'b0;
  logic        out_ctl_insert, out_ctl_pop;
  logic [31:0] out_pifo_input;
  logic [31:0] in_head_element = '0;
  logic [4:0]  out_count;
  logic        out_full, out_empty;

`ifdef PIFO_CTRL_CPU_WRITE_EN
  localparam bit CPU_EN = 1'b1;
`else
  localparam bit CPU_EN = 1'b0;
`endif

  pifo_root_ctrl dut (
    .clk(clk), .rstn(rstn),
    .in_insert_valid(in_insert_valid), .in_insert_data(in_insert_data),
    .out_insert_ready(out_insert_ready),
    .in_pop_req(in_pop_req), .out_pop_valid(out_pop_valid), .out_pop_data(out_pop_data),
    .in_cpu_wr_en(in_cpu_wr_en), .in_cpu_wr_data(in_cpu_wr_data), .out_cpu_wr_busy(out_cpu_wr_busy),
    .in_flush(in_flush), .out_ctl_insert(out_ctl_insert), .out_ctl_pop(out_ctl_pop),
    .out_pifo_input(out_pifo_input), .in_head_element(in_head_element),
    .out_count(out_count), .out_full(out_full), .out_empty(out_empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: the atom array as a rank-ordered queue, plus flush and CPU pending flags.
  logic [31:0] q[$];
  bit          m_flush = 0;
  bit          m_busy = 0;
  logic [31:0] m_cdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] rank(input logic [31:0] e);
    return e[30:12];
  endfunction

  function automatic logic [31:0] mk(input int r, input bit v);
    logic [18:0] rr;
    logic [11:0] tag;
    rr  = 19'(r);
    tag = 12'($urandom);
    return {v, rr, tag};
  endfunction

  task automatic q_insert(input logic [31:0] e);
    int idx = q.size();
    for (int i = 0; i < q.size(); i++)
      if (rank(q[i]) > rank(e)) begin idx = i; break; end
    q.insert(idx, e);
  endtask

  task automatic model_reset();
    q.delete();
    m_flush = 0;
    m_busy  = 0;
    in_head_element = '0;
  endtask

  task automatic step(input bit iv, input logic [31:0] id, input bit pr,
                      input bit cw, input logic [31:0] cd, input bit fl);
    bit idle, empty, full, grant, e_ready, hs, cgo, ev, e_ins, e_pop, e_pv;
    logic [31:0] el, e_pd;
    @(negedge clk);
    in_insert_valid = iv; in_insert_data = id; in_pop_req = pr;
    in_cpu_wr_en = cw; in_cpu_wr_data = cd; in_flush = fl;
    #1;
    idle    = !m_flush;
    empty   = (q.size() == 0);
    full    = (q.size() == 16);
    grant   = idle && pr && !empty;
    e_ready = idle && (!full || grant);
    hs      = iv && e_ready;
    cgo     = m_busy && idle && !hs && (!full || grant);
    el      = hs ? id : (cgo ? m_cdata : id);
    ev      = (hs || cgo) && el[31];
    e_ins = 0; e_pop = 0; e_pv = 0; e_pd = '0;
    check("count", 32'(out_count), 32'(q.size()));
    check("empty", 32'(out_empty), 32'(empty));
    check("full", 32'(out_full), 32'(full));
    check("busy", 32'(out_cpu_wr_busy), 32'(m_busy));
    check("ready", 32'(out_insert_ready), 32'(e_ready));
    check("pifo_input", out_pifo_input, el);
    if (!idle) begin
      e_pop = !empty;
      if (!empty) void'(q.pop_front());
      if (q.size() == 0) m_flush = 0;
    end else begin
      if (ev && pr) begin
        e_pv = 1;
        if (!empty && rank(el) >= rank(q[0])) begin
          e_ins = 1; e_pop = 1; e_pd = q.pop_front(); q_insert(el);
        end else e_pd = el;
      end else if (ev) begin
        e_ins = 1; q_insert(el);
      end else if (grant) begin
        e_pop = 1; e_pv = 1; e_pd = q.pop_front();
      end
      if (fl) m_flush = 1;
    end
    check("ctl_insert", 32'(out_ctl_insert), 32'(e_ins));
    check("ctl_pop", 32'(out_ctl_pop), 32'(e_pop));
    if (CPU_EN && cw && !m_busy) begin m_busy = 1; m_cdata = cd; end
    else if (cgo) m_busy = 0;
    @(posedge clk);
    #1;
    in_head_element = (q.size() != 0) ? q[0] : '0;
    check("pop_valid", 32'(out_pop_valid), 32'(e_pv));
    if (e_pv) check("pop_data", out_pop_data, e_pd);
  endtask

  task automatic idle_step();
    step(0, '0, 0, 0, '0, 0);
  endtask

  task automatic drain_flush();
    for (int i = 0; i < 20 && m_flush; i++) step(1, mk(3, 1), 1, 0, '0, 0);
    if (m_flush) check("flush_timeout", 32'(m_flush), 32'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_count", 32'(out_count), 32'(0));
    check("rst_empty", 32'(out_empty), 32'(1));
    check("rst_full", 32'(out_full), 32'(0));
    check("rst_ready", 32'(out_insert_ready), 32'(1));
    check("rst_ctl_insert", 32'(out_ctl_insert), 32'(0));
    check("rst_ctl_pop", 32'(out_ctl_pop), 32'(0));
    check("rst_pop_valid", 32'(out_pop_valid), 32'(0));
    check("rst_pop_data", out_pop_data, 32'(0));
    check("rst_busy", 32'(out_cpu_wr_busy), 32'(0));
  endtask

  initial begin
    #2;
    check_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;

    // ranks 5,2,9 then three pops
    step(1, mk(5, 1), 0, 0, '0, 0);
    step(1, mk(2, 1), 0, 0, '0, 0);
    step(1, mk(9, 1), 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, '0, 0);
    idle_step();

    // fill to 16 with head rank 0, stall at full, then pop+insert rank 1
    step(1, mk(0, 1), 0, 0, '0, 0);
    for (int i = 0; i < 15; i++) step(1, mk(2 + i, 1), 0, 0, '0, 0);
    step(1, mk(1, 1), 0, 0, '0, 0);
    step(1, mk(1, 1), 0, 0, '0, 0);
    step(1, mk(1, 1), 1, 0, '0, 0);
    step(0, '0, 0, 0, '0, 1);
    drain_flush();

    // bypass on empty array
    step(1, mk(7, 1), 1, 0, '0, 0);
    idle_step();

    // CPU write under three dataplane inserts
    step(1, mk(10, 1), 0, 1, mk(4, 1), 0);
    step(1, mk(11, 1), 0, 0, '0, 0);
    step(1, mk(12, 1), 0, 0, '0, 0);
    idle_step();
    idle_step();
    step(0, '0, 0, 0, '0, 1);
    drain_flush();

    // flush from count 5
    for (int i = 0; i < 5; i++) step(1, mk(i * 3, 1), 0, 0, '0, 0);
    step(0, '0, 0, 0, '0, 1);
    drain_flush();
    idle_step();

    // element with valid bit clear is swallowed
    step(1, mk(6, 0), 0, 0, '0, 0);
    step(1, mk(6, 0), 1, 0, '0, 0);
    idle_step();

    // async reset in the middle of a flush
    for (int i = 0; i < 5; i++) step(1, mk(i, 1), 0, 1, mk(8, 1), 0);
    step(0, '0, 0, 0, '0, 1);
    step(0, '0, 0, 0, '0, 0);
    @(negedge clk);
    in_insert_valid = 0; in_pop_req = 0; in_cpu_wr_en = 0; in_flush = 0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_reset_outputs();
    @(negedge clk);
    rstn = 1'b1;

    // randomized traffic; small rank range to exercise ties
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 1) == 1,
           mk($urandom_range(0, 15), $urandom_range(0, 7) != 0),
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) == 0,
           mk($urandom_range(0, 15), $urandom_range(0, 7) != 0),
           $urandom_range(0, 99) < 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
